vdiv_seq: RTL and testbench



---
 rtl/vdiv_seq_pkg.sv | 44 ++++
 rtl/vdiv_seq_lane_step.sv | 34 +++
 rtl/vdiv_seq.sv | 125 ++++++++++++
 tb/tb_vdiv_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vdiv_seq_pkg.sv
// Shared vector-unit definitions used by the VDIV/VMOD sequencer.
package vdiv_seq_pkg;

  // Lane width select encodings
  typedef enum logic [1:0] {
    Width_8  = 2'b00,
    Width_16 = 2'b01,
    Width_32 = 2'b10,
    Width_64 = 2'b11
  } width_e;

  // Vector opcodes routed to the sequencer
  localparam logic [5:0] VDIV = 6'b001110;
  localparam logic [5:0] VMOD = 6'b001111;

  // Width of a lane-width value (holds 8..64)
  localparam int unsigned LW_W = 7;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_CALC = 2'b10,
    S_DONE = 2'b11
  } vdiv_state_e;

  // Lane width in bits for a width select
  function automatic logic [LW_W-1:0] lane_width(input logic [1:0] ww);
    logic [LW_W-1:0] w;
    case (ww)
      Width_8:  w = 7'd8;
      Width_16: w = 7'd16;
      Width_32: w = 7'd32;
      default:  w = 7'd64;
    endcase
    return w;
  endfunction

  // Low-aligned mask of w ones
  function automatic logic [63:0] lane_mask(input logic [LW_W-1:0] w);
    return (w == 7'd64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/vdiv_seq_lane_step.sv
// One restoring-division bit: shift in a dividend bit, compare, conditionally subtract.
module vdiv_lane_step
  import vdiv_seq_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic [DW:0]      rem_i,
  input  logic             bit_i,
  input  logic [DW-1:0]    div_i,
  input  logic [LW_W-1:0]  w_i,
  output logic [DW:0]      rem_o,
  output logic             q_o
);

  localparam int unsigned RW = DW + 1;

  logic [RW-1:0] mask_c;
  logic [RW-1:0] r_c;
  logic [RW-1:0] d_c;
  logic [RW-1:0] diff_c;
  logic          unused_c;

  // Compare and subtract confined to the low W+1 bits of the shifted remainder
  always_comb begin
    mask_c   = (RW'(1) << (w_i + 7'd1)) - RW'(1);
    r_c      = {rem_i[DW-1:0], bit_i} & mask_c;
    d_c      = {1'b0, div_i};
    q_o      = (r_c >= d_c);
    diff_c   = (r_c - d_c) & mask_c;
    rem_o    = q_o ? diff_c : r_c;
    unused_c = rem_i[DW];
  end

endmodule

// File: rtl/vdiv_seq.sv
// Lane-serial unsigned VDIV/VMOD sequencer; stalls ID/EX for 64 calc cycles.
module vdiv_seq
  import vdiv_seq_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          op_mod_i,
  input  logic [1:0]    ww_i,
  input  logic [DW-1:0] op_a_i,
  input  logic [DW-1:0] op_b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] result_o
);

  vdiv_state_e     state_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [DW-2:0]   q_q;
  logic [DW:0]     rem_q;
  logic [LW_W-1:0] w_q;
  logic            mod_q;
  logic [LW_W-1:0] bit_q;
  logic [2:0]      lane_q;
  logic [5:0]      calc_q;
  logic [DW-1:0]   result_q;
  logic            busy_q;
  logic            done_q;

  logic [DW-1:0]   div_c;
  logic [DW:0]     rem_d;
  logic            qbit_c;
  logic [DW-1:0]   q_d;
  logic [DW-1:0]   lmask_c;
  logic [LW_W-1:0] pos_c;
  logic [DW-1:0]   lane_val_c;
  logic [DW-1:0]   result_d;
  logic            last_bit_c;

  vdiv_lane_step #(.DW(DW)) u_step (
    .rem_i (rem_q),
    .bit_i (a_q[DW-1]),
    .div_i (div_c),
    .w_i   (w_q),
    .rem_o (rem_d),
    .q_o   (qbit_c)
  );

  // Current-lane divisor, lane write-back position and merged result
  always_comb begin
    div_c      = b_q >> (7'(DW) - w_q);
    lmask_c    = lane_mask(w_q);
    q_d        = {q_q, qbit_c};
    pos_c      = 7'(DW) - w_q - (7'(lane_q) * w_q);
    lane_val_c = (mod_q ? rem_d[DW-1:0] : q_d) & lmask_c;
    result_d   = (result_q & ~(lmask_c << pos_c)) | (lane_val_c << pos_c);
    last_bit_c = (bit_q == (w_q - 7'd1));
  end

  // FSM, counters, shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      w_q      <= '0;
      mod_q    <= 1'b0;
      bit_q    <= '0;
      lane_q   <= '0;
      calc_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_q == S_LOAD) || (state_q == S_CALC);
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start_i) state_q <= S_LOAD;
        end
        S_LOAD: begin
          a_q     <= op_a_i;
          b_q     <= op_b_i;
          w_q     <= lane_width(ww_i);
          mod_q   <= op_mod_i;
          q_q     <= '0;
          rem_q   <= '0;
          bit_q   <= '0;
          lane_q  <= '0;
          calc_q  <= '0;
          state_q <= S_CALC;
        end
        S_CALC: begin
          a_q    <= a_q << 1;
          q_q    <= q_d[DW-2:0];
          calc_q <= calc_q + 6'd1;
          if (last_bit_c) begin
            result_q <= result_d;
            rem_q    <= '0;
            bit_q    <= '0;
            lane_q   <= lane_q + 3'd1;
            b_q      <= b_q << w_q;
          end else begin
            rem_q <= rem_d;
            bit_q <= bit_q + 7'd1;
          end
          if (calc_q == 6'd63) state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_vdiv_seq.sv
// Self-checking bench for vdiv_seq against an arithmetic lane-division model.
module tb_vdiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_mod;
  logic [1:0]  ww;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks;
  int errors;

  vdiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .op_mod_i (op_mod),
    .ww_i     (ww),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector: per-lane unsigned / or %, lane 0 in the top bits
  function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] w, input logic m);
    int          wd;
    int          n;
    int          sh;
    logic [63:0] mk;
    logic [63:0] al;
    logic [63:0] bl;
    logic [63:0] v;
    logic [63:0] res;
    wd  = 8 << w;
    n   = 64 / wd;
    mk  = (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wd) - 64'd1);
    res = '0;
    for (int i = 0; i < n; i++) begin
      sh = 64 - (i + 1) * wd;
      al = (a >> sh) & mk;
      bl = (b >> sh) & mk;
      if (bl == 64'd0) v = m ? al : mk;
      else             v = m ? (al % bl) : (al / bl);
      res = res | (v << sh);
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation: check latency, busy window, single done pulse and result
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] w, input logic m, input bit inject,
                       output logic [63:0] res);
    int          done_cyc;
    int          done_cnt;
    logic        b1, b65, b66;
    logic [63:0] exp;
    exp      = ref_op(a, b, w, m);
    res      = '0;
    done_cyc = -1;
    done_cnt = 0;
    b1 = 1'b0; b65 = 1'b0; b66 = 1'b1;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; ww = w; op_mod = m;
    @(posedge clk); #1;
    chk({tag, "_busy_k"}, 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
        ww = 2'($urandom); op_mod = ~m;
      end
      if (inject && c == 10) begin
        start = 1'b1; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      end
      if (inject && c == 11) start = 1'b0;
      if (c == 1)  b1  = busy;
      if (c == 65) b65 = busy;
      if (c == 66) b66 = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res = result;
        end
      end
    end
    chk({tag, "_done_cyc"}, 64'(done_cyc), 64'd66);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_k1"}, 64'(b1), 64'd1);
    chk({tag, "_busy_k65"}, 64'(b65), 64'd1);
    chk({tag, "_busy_k66"}, 64'(b66), 64'd0);
    chk({tag, "_result"}, res, exp);
  endtask

  logic [63:0] r;
  logic [63:0] ra, rb;
  logic [63:0] exp_b2b;
  logic        dprev;
  int          dn;

  initial begin
    rst_n = 1'b0; start = 1'b0; op_mod = 1'b0; ww = 2'b00; op_a = '0; op_b = '0;
    checks = 0; errors = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    #17 rst_n = 1'b1;

    do_op("div8", 64'hC8C8_C8C8_C8C8_C8C8, 64'h0707_0707_0707_0707, 2'b00, 1'b0, 1'b0, r);
    chk("div8_const", r, 64'h1C1C_1C1C_1C1C_1C1C);
    do_op("mod8", 64'hC8C8_C8C8_C8C8_C8C8, 64'h0707_0707_0707_0707, 2'b00, 1'b1, 1'b0, r);
    chk("mod8_const", r, 64'h0404_0404_0404_0404);
    do_op("div64", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 2'b11, 1'b0, 1'b0, r);
    chk("div64_const", r, 64'h0FFF_FFFF_FFFF_FFFF);
    do_op("mod64", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 2'b11, 1'b1, 1'b0, r);
    chk("mod64_const", r, 64'h0000_0000_0000_000F);
    do_op("dz16_div", 64'h1111_2222_1234_4444, 64'h0003_0005_0000_0007, 2'b01, 1'b0, 1'b0, r);
    chk("dz16_div_lane2", 64'(r[31:16]), 64'hFFFF);
    do_op("dz16_mod", 64'h1111_2222_1234_4444, 64'h0003_0005_0000_0007, 2'b01, 1'b1, 1'b0, r);
    chk("dz16_mod_lane2", 64'(r[31:16]), 64'h1234);

    do_op("ignore", 64'h0123_4567_89AB_CDEF, 64'h0000_0101_0000_0033, 2'b10, 1'b0, 1'b1, r);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op_a = 64'hDEAD_BEEF_CAFE_F00D; op_b = 64'h0102_0304_0506_0708;
    ww = 2'b00; op_mod = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 64'hDEAD_BEEF_CAFE_F00D, 64'h0102_0304_0506_0708, 2'b00, 1'b1, 1'b0, r);

    // Random operands, small divisors and occasional zero divisors
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 48);
      if (i == 3) rb = '0;
      do_op("rand", ra, rb, 2'($urandom), 1'($urandom), 1'b0, r);
    end

    // start held high: one done every 67 cycles
    exp_b2b = ref_op(64'h8765_4321_0FED_CBA9, 64'h0000_0013_0000_0000, 2'b10, 1'b0);
    @(negedge clk);
    start = 1'b1; op_a = 64'h8765_4321_0FED_CBA9; op_b = 64'h0000_0013_0000_0000;
    ww = 2'b10; op_mod = 1'b0;
    dprev = 1'b0;
    dn = 0;
    for (int c = 0; c <= 205; c++) begin
      @(posedge clk); #1;
      if (c >= 1) chk("b2b_busy", 64'(busy), 64'(!(done || dprev)));
      if (done) begin
        chk("b2b_done_at", 64'(c), 64'(66 + 67 * dn));
        chk("b2b_result", result, exp_b2b);
        dn++;
      end
      dprev = done;
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_count", 64'(dn), 64'd3);
    repeat (80) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
